// File: rtl/weight_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : weight_bank_if
// Description : Bundles the control, delta-accumulate and weight-readout
//               signals of weight_bank. The master modport belongs to the
//               controller / delta datapath, and the slave modport belongs
//               to the weight bank itself.
//   init       m->s  pulse: reload INIT weights, clear accumulators and flags
//   acc_valid  m->s  delta presented this cycle
//   acc_idx    m->s  target weight index (IW bits)
//   acc_dw     m->s  signed delta weight (W bits)
//   commit     m->s  pulse: fold all accumulators into the weights
//   acc_ready  s->m  high only while the bank is idle
//   busy       s->m  high while the commit sweep runs
//   done       s->m  one-cycle pulse when a commit completes
//   w_flat     s->m  all N weights, packed, weight i at [i*W +: W]
//   sat_flag   s->m  sticky per-weight clip flags
// Revision    : 1.0 - initial release
// ============================================================================
interface weight_bank_if #(
    parameter int W = 16,
    parameter int N = 4
) ();
    localparam int IW = $clog2(N);

    logic                 init;
    logic                 acc_valid;
    logic [IW-1:0]        acc_idx;
    logic signed [W-1:0]  acc_dw;
    logic                 acc_ready;
    logic                 commit;
    logic                 busy;
    logic                 done;
    logic [N*W-1:0]       w_flat;
    logic [N-1:0]         sat_flag;

    modport master (
        output init, acc_valid, acc_idx, acc_dw, commit,
        input  acc_ready, busy, done, w_flat, sat_flag
    );

    modport slave (
        input  init, acc_valid, acc_idx, acc_dw, commit,
        output acc_ready, busy, done, w_flat, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/weight_bank.sv
`default_nettype none
// ============================================================================
// Module      : weight_bank
// Description : Bank of N signed fixed-point weights for one network layer.
//               During a batch, deltas are summed per weight into W+G bit
//               saturating accumulators. A commit then folds each accumulator
//               into its weight, one weight per cycle, clipping the result to
//               W bits and recording the clips in sticky flags.
//   clk    in   clock, rising edge
//   reset  in   asynchronous reset, active low (weights go to 0, not INIT)
//   bus    slave modport of weight_bank_if (see that file for the signals)
// Revision    : 1.0 - initial release
// ============================================================================
module weight_bank #(
    parameter int             W    = 16,
    parameter int             N    = 4,
    parameter int             G    = 4,
    parameter logic [N*W-1:0] INIT = {N{16'sd409}}
) (
    input  wire logic    clk,
    input  wire logic    reset,
    weight_bank_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int AW = W + G;          // accumulator width
    localparam int SW = AW + 1;         // one extra bit for the overflow check

    localparam logic signed [AW-1:0] C_ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] C_ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [W-1:0]  C_W_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  C_W_MIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic [IW-1:0]        C_LAST    = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COMMIT = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;
    logic signed [W-1:0]  r_w   [N];
    logic signed [AW-1:0] r_acc [N];
    logic [N-1:0]         r_sat;
    logic [IW-1:0]        r_ci;
    logic                 r_busy;
    logic                 r_done;

    // ------------------------------------------------------------------
    // Datapath wires
    // ------------------------------------------------------------------
    logic signed [AW-1:0] w_acc_sel;    // accumulator addressed by acc_idx
    logic signed [AW-1:0] w_dw_ext;     // delta sign-extended to AW
    logic signed [SW-1:0] w_acc_sum;
    logic signed [AW-1:0] w_acc_new;
    logic signed [W-1:0]  w_cw;         // weight addressed by the commit index
    logic signed [AW-1:0] w_cacc;       // accumulator addressed by the commit index
    logic signed [SW-1:0] w_cs;
    logic                 w_cs_ovf;
    logic signed [W-1:0]  w_wnew;
    logic [N*W-1:0]       w_flat_pack;

    // Read muxes. An acc_idx at or beyond N matches no entry, which is what
    // makes out-of-range deltas fall away without any extra range check.
    always_comb begin
        w_acc_sel = '0;
        w_cacc    = '0;
        w_cw      = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.acc_idx == IW'(i)) begin
                w_acc_sel = r_acc[i];
            end
            if (r_ci == IW'(i)) begin
                w_cacc = r_acc[i];
                w_cw   = r_w[i];
            end
        end
    end

    // Accumulate: one extra bit of headroom, then clamp back to AW bits.
    // The top two bits of the sum differ exactly when AW bits overflowed.
    always_comb begin
        w_dw_ext  = {{G{bus.acc_dw[W-1]}}, bus.acc_dw};
        w_acc_sum = {w_acc_sel[AW-1], w_acc_sel} + {w_dw_ext[AW-1], w_dw_ext};
        if (w_acc_sum[SW-1] != w_acc_sum[SW-2]) begin
            w_acc_new = w_acc_sum[SW-1] ? C_ACC_MIN : C_ACC_MAX;
        end else begin
            w_acc_new = w_acc_sum[AW-1:0];
        end
    end

    // Commit: the sum fits in W bits only when all bits from W-1 upwards
    // equal the sign. Otherwise the sum is clipped toward its own sign.
    always_comb begin
        w_cs     = {{(G+1){w_cw[W-1]}}, w_cw} + {w_cacc[AW-1], w_cacc};
        w_cs_ovf = !((&w_cs[SW-1:W-1]) || !(|w_cs[SW-1:W-1]));
        if (w_cs_ovf) begin
            w_wnew = w_cs[SW-1] ? C_W_MIN : C_W_MAX;
        end else begin
            w_wnew = w_cs[W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register plus registered busy/done derived from the
    // next state, so that both outputs line up with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_COMMIT);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.init) begin
            // init aborts any sweep in progress; the DONE pulse is skipped
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A delta outranks commit, so a coincident commit is lost
                    if (!bus.acc_valid && bus.commit) begin
                        w_state_nxt = S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    if (r_ci == C_LAST) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Weights, accumulators, sticky flags and the sweep index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                r_w[i]   <= '0;
                r_acc[i] <= '0;
            end
            r_sat <= '0;
            r_ci  <= '0;
        end else if (bus.init) begin
            for (int i = 0; i < N; i++) begin
                r_w[i]   <= INIT[i*W +: W];
                r_acc[i] <= '0;
            end
            r_sat <= '0;
            r_ci  <= '0;
        end else if (r_state == S_IDLE) begin
            if (bus.acc_valid) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.acc_idx == IW'(i)) begin
                        r_acc[i] <= w_acc_new;
                    end
                end
            end else if (bus.commit) begin
                r_ci <= '0;
            end
        end else if (r_state == S_COMMIT) begin
            for (int i = 0; i < N; i++) begin
                if (r_ci == IW'(i)) begin
                    r_w[i]   <= w_wnew;
                    r_acc[i] <= '0;
                    if (w_cs_ovf) begin
                        r_sat[i] <= 1'b1;
                    end
                end
            end
            r_ci <= r_ci + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_flat_pack = '0;
        for (int i = 0; i < N; i++) begin
            w_flat_pack[i*W +: W] = r_w[i];
        end
    end

    assign bus.w_flat    = w_flat_pack;
    assign bus.sat_flag  = r_sat;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.acc_ready = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_weight_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_bank
// Description : Self-checking bench for weight_bank. A behavioural model
//               (integer weights, accumulators and flags) predicts the
//               weights and flags. A second instance with N=5 covers the
//               dropping of out-of-range delta indices.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_weight_bank;
    localparam int W     = 16;
    localparam int N     = 4;
    localparam int G     = 4;
    localparam int IW    = 2;
    localparam int N5    = 5;
    localparam int IW5   = 3;
    localparam int AMAX  = (1 << (W+G-1)) - 1;
    localparam int AMIN  = -(1 << (W+G-1));
    localparam int WMAX  = 32767;
    localparam int WMIN  = -32768;
    localparam int INITV = 409;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    weight_bank_if #(.W(W), .N(N))  bus ();
    weight_bank_if #(.W(W), .N(N5)) bus5 ();

    weight_bank #(.W(W), .N(N),  .G(G)) dut  (.clk(clk), .reset(reset), .bus(bus));
    weight_bank #(.W(W), .N(N5), .G(G)) dut5 (.clk(clk), .reset(reset), .bus(bus5));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    int           m_w   [N];
    int           m_acc [N];
    logic [N-1:0] m_sat;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic m_fill(input int wv);
        for (int i = 0; i < N; i++) begin
            m_w[i]   = wv;
            m_acc[i] = 0;
        end
        m_sat = '0;
    endtask

    task automatic m_delta(input int idx, input int dw);
        if (idx < N) m_acc[idx] = clampi(m_acc[idx] + dw, AMIN, AMAX);
    endtask

    task automatic m_commit();
        int s;
        for (int i = 0; i < N; i++) begin
            s = m_w[i] + m_acc[i];
            if (s > WMAX || s < WMIN) m_sat[i] = 1'b1;
            m_w[i]   = clampi(s, WMIN, WMAX);
            m_acc[i] = 0;
        end
    endtask

    function automatic logic [N*W-1:0] m_flat();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(m_w[i]);
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init();
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        m_fill(INITV);
    endtask

    task automatic send(input int idx, input int dw);
        bus.acc_valid = 1'b1;
        bus.acc_idx   = IW'(idx);
        bus.acc_dw    = W'(dw);
        tick();
        bus.acc_valid = 1'b0;
        m_delta(idx, dw);
    endtask

    // Commit with cycle-accurate checks of busy/done/ready and of the
    // weight sweep (weight i changes at edge i+1).
    task automatic commit_check(input string tag);
        logic [N*W-1:0] pre, post, expc;
        logic [N-1:0]   sat_exp;
        pre = m_flat();
        m_commit();
        post    = m_flat();
        sat_exp = m_sat;
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        for (int c = 1; c <= N; c++) begin
            for (int i = 0; i < N; i++) expc[i*W +: W] = (i < c - 1) ? post[i*W +: W] : pre[i*W +: W];
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.acc_ready !== 1'b0 || bus.w_flat !== expc) begin
                errors++;
                $display("FAIL %s sweep cycle %0d: busy=%b done=%b ready=%b w=%h, expected 1 0 0 w=%h",
                         tag, c, bus.busy, bus.done, bus.acc_ready, bus.w_flat, expc);
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.acc_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done cycle: done=%b busy=%b ready=%b, expected 1 0 0", tag, bus.done, bus.busy, bus.acc_ready);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.acc_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready cycle: done=%b ready=%b, expected 0 1", tag, bus.done, bus.acc_ready);
        end
        checks++;
        if (bus.w_flat !== post) begin
            errors++;
            $display("FAIL %s weights: got %h expected %h", tag, bus.w_flat, post);
        end
        checks++;
        if (bus.sat_flag !== sat_exp) begin
            errors++;
            $display("FAIL %s sat_flag: got %b expected %b", tag, bus.sat_flag, sat_exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [N*W-1:0] exp_init;
        exp_init = {4{16'sd409}};
        #12;
        checks++;
        if (bus.w_flat !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sat_flag !== '0) begin
            errors++;
            $display("FAIL reset outputs: w=%h busy=%b done=%b sat=%b, expected all 0", bus.w_flat, bus.busy, bus.done, bus.sat_flag);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_fill(0);
        tick();
        checks++;
        if (bus.acc_ready !== 1'b1 || bus.w_flat !== '0) begin
            errors++;
            $display("FAIL reset release: ready=%b w=%h, expected 1 and 0", bus.acc_ready, bus.w_flat);
        end
        do_init();
        checks++;
        if (bus.w_flat !== exp_init || bus.sat_flag !== '0 || bus.acc_ready !== 1'b1) begin
            errors++;
            $display("FAIL init load: w=%h sat=%b ready=%b, expected %h 0 1", bus.w_flat, bus.sat_flag, bus.acc_ready, exp_init);
        end
    endtask

    task automatic test_accum_commit();
        logic [N*W-1:0] exp_w;
        exp_w = {16'sd409, 16'sd613, 16'sd409, 16'sd359};
        do_init();
        send(2, 102);
        send(2, 102);
        send(0, -50);
        commit_check("accum");
        checks++;
        if (bus.w_flat !== exp_w) begin
            errors++;
            $display("FAIL accum directed: got %h expected %h", bus.w_flat, exp_w);
        end
        commit_check("accum_recommit");
        checks++;
        if (bus.w_flat !== exp_w) begin
            errors++;
            $display("FAIL accum cleared: got %h expected %h", bus.w_flat, exp_w);
        end
    endtask

    task automatic test_saturation();
        do_init();
        send(1, 32767);
        send(1, 32767);
        send(3, -32768);
        send(3, -32768);
        commit_check("wsat");
        checks++;
        if (bus.w_flat[1*W +: W] !== 16'h7fff || bus.w_flat[3*W +: W] !== 16'h8000 || bus.sat_flag !== 4'b1010) begin
            errors++;
            $display("FAIL wsat directed: w1=%h w3=%h sat=%b, expected 7fff 8000 1010",
                     bus.w_flat[1*W +: W], bus.w_flat[3*W +: W], bus.sat_flag);
        end
        send(0, 5);
        commit_check("wsat_sticky");
        checks++;
        if (bus.sat_flag !== 4'b1010) begin
            errors++;
            $display("FAIL wsat sticky: got %b expected 1010", bus.sat_flag);
        end
    endtask

    // 20 max positive deltas overflow the accumulator; if it clamps, the
    // following 20 max negatives drive the weight to the negative rail.
    task automatic test_acc_saturation();
        do_init();
        for (int k = 0; k < 20; k++) send(0, 32767);
        for (int k = 0; k < 20; k++) send(0, -32768);
        commit_check("accsat");
        checks++;
        if (bus.w_flat[0 +: W] !== 16'h8000 || bus.sat_flag !== 4'b0001) begin
            errors++;
            $display("FAIL accsat directed: w0=%h sat=%b, expected 8000 0001", bus.w_flat[0 +: W], bus.sat_flag);
        end
    endtask

    task automatic test_abort();
        logic [N*W-1:0] exp_init;
        int             seen;
        exp_init = {4{16'sd409}};
        do_init();
        send(3, 100);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        tick();                     // second cycle of the sweep
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        m_fill(INITV);
        checks++;
        if (bus.w_flat !== exp_init || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.acc_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort: w=%h busy=%b done=%b ready=%b, expected %h 0 0 1",
                     bus.w_flat, bus.busy, bus.done, bus.acc_ready, exp_init);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort done pulse: got %0d pulses expected 0", seen);
        end
        commit_check("abort_recommit");
        checks++;
        if (bus.w_flat !== exp_init) begin
            errors++;
            $display("FAIL abort acc cleared: got %h expected %h", bus.w_flat, exp_init);
        end
    endtask

    task automatic test_ignored();
        logic [N*W-1:0] exp_init;
        logic [N*W-1:0] exp_w;
        exp_init = {4{16'sd409}};
        do_init();
        send(1, 200);
        m_commit();
        exp_w = m_flat();
        bus.commit = 1'b1;
        tick();
        // hold a delta and a commit request across the whole sweep
        bus.acc_valid = 1'b1;
        bus.acc_idx   = 2'd2;
        bus.acc_dw    = 16'sd1000;
        for (int c = 1; c <= N; c++) begin
            checks++;
            if (bus.acc_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL ignored ready cycle %0d: ready=%b busy=%b, expected 0 1", c, bus.acc_ready, bus.busy);
            end
            tick();
        end
        bus.acc_valid = 1'b0;
        bus.commit    = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.w_flat !== exp_w || bus.busy !== 1'b0 || bus.acc_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignored result: w=%h busy=%b ready=%b, expected %h 0 1", bus.w_flat, bus.busy, bus.acc_ready, exp_w);
        end
        // delta and commit together: the commit is dropped
        bus.acc_valid = 1'b1;
        bus.acc_idx   = 2'd0;
        bus.acc_dw    = 16'sd10;
        bus.commit    = 1'b1;
        tick();
        bus.acc_valid = 1'b0;
        bus.commit    = 1'b0;
        m_delta(0, 10);
        checks++;
        if (bus.busy !== 1'b0 || bus.acc_ready !== 1'b1) begin
            errors++;
            $display("FAIL delta+commit: busy=%b ready=%b, expected 0 1", bus.busy, bus.acc_ready);
        end
        commit_check("delta_then_commit");
        // init, delta and commit together: only init acts
        bus.init      = 1'b1;
        bus.acc_valid = 1'b1;
        bus.acc_idx   = 2'd0;
        bus.acc_dw    = 16'sd777;
        bus.commit    = 1'b1;
        tick();
        bus.init      = 1'b0;
        bus.acc_valid = 1'b0;
        bus.commit    = 1'b0;
        m_fill(INITV);
        checks++;
        if (bus.busy !== 1'b0 || bus.w_flat !== exp_init || bus.sat_flag !== '0) begin
            errors++;
            $display("FAIL init priority: busy=%b w=%h sat=%b, expected 0 %h 0", bus.busy, bus.w_flat, bus.sat_flag, exp_init);
        end
        commit_check("init_priority");
    endtask

    task automatic test_random();
        logic signed [W-1:0] r16;
        int                  dw, idx;
        logic                v;
        do_init();
        for (int round = 0; round < 8; round++) begin
            if (round == 4) do_init();
            for (int k = 0; k < 30; k++) begin
                v   = ($urandom_range(0, 3) != 0);
                idx = $urandom_range(0, N - 1);
                if ($urandom_range(0, 3) == 0) begin
                    r16 = W'($urandom);
                    dw  = r16;
                end else begin
                    dw = $urandom_range(0, 1024) - 512;
                end
                bus.acc_valid = v;
                bus.acc_idx   = IW'(idx);
                bus.acc_dw    = W'(dw);
                tick();
                bus.acc_valid = 1'b0;
                if (v) m_delta(idx, dw);
            end
            commit_check("random");
        end
    endtask

    task automatic test_async_reset();
        do_init();
        send(1, 32767);
        send(1, 32767);
        commit_check("pre_async");
        send(2, 50);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        tick();
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.w_flat !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sat_flag !== '0 || bus.acc_ready !== 1'b1) begin
            errors++;
            $display("FAIL async reset: w=%h busy=%b done=%b sat=%b ready=%b, expected 0 0 0 0 1",
                     bus.w_flat, bus.busy, bus.done, bus.sat_flag, bus.acc_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_fill(0);
        tick();
        commit_check("post_async");
    endtask

    task automatic test_n5();
        logic [N5*W-1:0] exp5;
        int              got;
        exp5 = {16'sd419, 16'sd409, 16'sd409, 16'sd409, 16'sd409};
        bus5.init = 1'b1;
        tick();
        bus5.init = 1'b0;
        for (int k = 4; k < 8; k++) begin
            bus5.acc_valid = 1'b1;
            bus5.acc_idx   = IW5'(k);
            bus5.acc_dw    = (k == 4) ? 16'sd10 : 16'sd7;
            tick();
        end
        bus5.acc_valid = 1'b0;
        bus5.commit    = 1'b1;
        tick();
        bus5.commit = 1'b0;
        got = 0;
        for (int c = 0; c < 12 && got == 0; c++) begin
            if (bus5.done === 1'b1) got = 1;
            else tick();
        end
        checks++;
        if (got != 1) begin
            errors++;
            $display("FAIL n5 done: no done pulse within 12 cycles");
        end
        tick();
        checks++;
        if (bus5.w_flat !== exp5 || bus5.sat_flag !== '0) begin
            errors++;
            $display("FAIL n5 index drop: w=%h sat=%b expected %h 0", bus5.w_flat, bus5.sat_flag, exp5);
        end
    endtask

    initial begin
        bus.init       = 1'b0;
        bus.acc_valid  = 1'b0;
        bus.acc_idx    = '0;
        bus.acc_dw     = '0;
        bus.commit     = 1'b0;
        bus5.init      = 1'b0;
        bus5.acc_valid = 1'b0;
        bus5.acc_idx   = '0;
        bus5.acc_dw    = '0;
        bus5.commit    = 1'b0;

        test_reset();
        test_accum_commit();
        test_saturation();
        test_acc_saturation();
        test_abort();
        test_ignored();
        test_random();
        test_async_reset();
        test_n5();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/weight_bank.md
# weight_bank

Parametrised bank of N signed fixed-point weight registers for the backpropagation network: replaces the per-weight update registers with one block holding all weights of a layer. Delta weights are accumulated per weight in guarded accumulators during a batch, then committed with saturation, one weight per cycle, under a busy/done handshake. The block sits between the delta-weight datapath and the forward-pass multipliers, which read all weights in parallel from `w_flat`.

## Interface
- `W`, 16: weight and delta width, signed two's complement, format 00_0000.0000_0000_00 (10 fractional bits).
- `N`, 4: number of weights in the bank (N ≥ 2).
- `G`, 4: accumulator guard bits; accumulators are W+G bits wide.
- `INIT`, {N{16'sd409}}: packed N×W initial values, weight i at bits [i*W +: W]; 409 = 0.4.
- `IW` (localparam) = clog2(N).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous reset, active-low.
- `init`  in  1  pulse: load INIT into all weights, clear accumulators and flags.
- `acc_valid`  in  1  delta presented this cycle.
- `acc_idx`  in  IW  target weight index.
- `acc_dw`  in  W  signed delta weight.
- `acc_ready`  out  1  high only in IDLE; a delta is taken when acc_valid & acc_ready.
- `commit`  in  1  pulse: apply all accumulators to the weights.
- `busy`  out  1  high while in COMMIT.
- `done`  out  1  one-cycle pulse when a commit completes.
- `w_flat`  out  N*W  current weights, packed like INIT, registered.
- `sat_flag`  out  N  sticky: weight i was clipped on a commit.

## Operation
- FSM states: IDLE, COMMIT, DONE. Index counter `ci` (IW bits).
- IDLE:
  - `init` loads w[i] = INIT[i], acc[i] = 0 and sat_flag = 0; stays in IDLE.
  - Else if acc_valid: acc[acc_idx] = sat_{W+G}(acc[acc_idx] + sext(acc_dw)). If acc_idx ≥ N, the delta is dropped with no state change.
  - Else if commit: ci = 0, go to COMMIT.
  - Priority when signals coincide: init > acc_valid > commit. A commit in the same cycle as an accepted delta is dropped.
- COMMIT, one weight per cycle:
  - s = w[ci] + acc[ci], computed at W+G+1 bits.
  - w[ci] = clip(s) to [-2^(W-1), 2^(W-1)-1].
  - sat_flag[ci] |= (s was out of range).
  - acc[ci] = 0.
  - ci++. After ci = N-1, go to DONE.
- DONE: `done` = 1 for one cycle, then return to IDLE.
- `init` in COMMIT or DONE aborts the commit. It performs the IDLE init load, goes to IDLE, and `done` is not asserted.
- `commit` outside IDLE and `acc_valid` outside IDLE are ignored; no queueing.
- Accumulator saturation clips at ±2^(W+G-1) bounds. It does not set sat_flag; only weight clipping does.
- Reset (`reset` = 0): asynchronously, all w = 0 (not INIT), acc = 0, sat_flag = 0, state = IDLE, ci = 0, busy = 0, done = 0. `acc_ready` = 1 once reset is released, since the FSM is in IDLE.

## Timing
- Delta accumulate: sampled at edge k; visible in acc at k+1. Back-to-back deltas to the same index every cycle are legal and must all be summed.
- Commit sampled at edge 0:
  - busy = 1 during cycles 1..N.
  - w[i] updates at edge i+1.
  - done = 1 during cycle N+1.
  - acc_ready = 1 again from cycle N+2.
  - Total latency is N+2 cycles, commit to ready.
- w_flat, busy, done and sat_flag are registered outputs. acc_ready is decoded from the state register.
- Reset assertion mid-commit takes effect immediately, without waiting for a clock edge. Partially committed weights are lost (all become 0).

## Test plan
- Reset then init: release reset, pulse init → next cycle w_flat = {409,409,409,409}, sat_flag = 0, acc_ready = 1.
- Accumulate/commit: init; deltas +102 to idx 2 on two consecutive cycles, −50 to idx 0; commit → w = {359,409,613,409}. busy for 4 cycles, done in cycle 5, accumulators zero afterwards (a second commit leaves w unchanged).
- Saturation: init; deltas +32767 twice to idx 1 and −32768 twice to idx 3; commit → w1 = 32767, w3 = −32768, sat_flag = 4'b1010. Flags stay set after a further clean commit.
- Abort: init; delta +100 to idx 3; commit; assert init in cycle 2 of COMMIT → next cycle w = all 409, busy = 0, no done pulse, and a subsequent commit leaves w = all 409.
- Collisions/ignored inputs: acc_valid while busy → acc_ready = 0, no effect. acc_idx = 4 with a modified N = 5 bench versus idx ≥ N with N = 4 → dropped. init + acc_valid + commit in the same cycle → only init takes effect.
- Async reset: assert reset between edges mid-commit → w_flat, busy, done and sat_flag all 0 before the next clock edge.
